fetch_top: RTL and testbench
============================

Name: fetch_top

Overview:
- Producer end of the IF→ID boundary: generates `pc`/`instruction` consumed by decode_top.
- Honours decode's hazard outputs `pc_write` and `if_id_write`, and the M-stage branch redirect.
- Fetches from a variable-latency instruction memory over a req/ready handshake.
- Owns the PC register and the IF/ID boundary registers. Inserts NOP bubbles on misses and flushes.

Parameters:
- ADDR_SIZE, 32, PC/address width (= `ADDR_SIZE).
- INSTR_SIZE, 32, instruction width (= `INSTR_SIZE).
- RESET_PC, 32'h0000_1000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, encoding injected as a bubble.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_write  in  1  from decode; 0 = hold PC (hazard stall).
- if_id_write  in  1  from decode; 0 = hold IF/ID outputs.
- branch_taken  in  1  from M stage; redirect fetch this cycle.
- branch_target  in  ADDR_SIZE  redirect address, valid with branch_taken.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_SIZE  request address; stable while imem_req=1 until imem_ready.
- imem_rdata  in  INSTR_SIZE  fetched word; valid only when imem_ready=1.
- imem_ready  in  1  single-cycle completion; may assert in the same cycle as imem_req.
- out_pc  out  ADDR_SIZE  IF/ID register: PC of `instruction`.
- instruction  out  INSTR_SIZE  IF/ID register: instruction to decode.
- out_valid  out  1  IF/ID register: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, reset=0): pc_reg=RESET_PC; out_pc=0; instruction=NOP_INSTR; out_valid=0; hold_instr=0; redirect_pc=0; state=IDLE; imem_req=0.
- stall = ~pc_write | ~if_id_write.
- Priority: branch_taken > stall > normal advance.
- imem_req=1 only in REQ and DRAIN. imem_addr=pc_reg in both states; otherwise don't-care, driven pc_reg.
- IDLE: one cycle after reset release, then → REQ. No request.
- REQ, imem_ready=1:
  - branch_taken: discard rdata; pc_reg←branch_target; bubble IF/ID; stay REQ.
  - else stall: hold_instr←rdata; IF/ID unchanged; → HELD.
  - else: IF/ID←{pc_reg, rdata, valid=1}; pc_reg←pc_reg+4; stay REQ.
- REQ, imem_ready=0:
  - branch_taken: redirect_pc←branch_target; bubble IF/ID; → DRAIN. pc_reg unchanged, so the address stays stable.
  - else: bubble IF/ID if if_id_write=1, else hold it.
- DRAIN: keep requesting the old pc_reg.
  - branch_taken again: redirect_pc←new target (latest wins); bubble.
  - On imem_ready: discard rdata; pc_reg←redirect_pc (or branch_target if branch_taken that cycle); → REQ.
  - IF/ID is a bubble for every cycle in DRAIN.
- HELD: imem_req=0.
  - branch_taken: drop hold_instr; pc_reg←branch_target; bubble; → REQ.
  - else if stall=0: IF/ID←{pc_reg, hold_instr, 1}; pc_reg←pc_reg+4; → REQ.
  - else: hold.
- Bubble = {out_pc←0, instruction←NOP_INSTR, out_valid←0}. A branch flush bubbles even when if_id_write=0.
- PC arithmetic: +4, modulo 2^ADDR_SIZE. 32'hFFFF_FFFC wraps to 0 with no flag. branch_target is used verbatim; no alignment check.
- Latency: zero-wait memory gives 1 instruction/cycle. The instruction appears on IF/ID the cycle after imem_ready.
- Reset mid-request: state→IDLE immediately. Any late imem_ready is ignored; memory must tolerate an abandoned request.

Decomposition:
- Shared define.v gets: `ADDR_SIZE, `INSTR_SIZE, `NOP_INSTR, `RESET_PC, and the fetch state encodings (IDLE=2'd0, REQ=2'd1, DRAIN=2'd2, HELD=2'd3).
- One natural sub-module: fetch_fsm (state, redirect_pc, hold_instr, next-PC select).
- IF/ID output registers remain in fetch_top.

Test Plan:
- Reset/zero-wait: release reset; imem_ready tied to imem_req; rdata=addr^32'hA5A5A5A5.
  - Expect imem_req low 1 cycle, then addresses 0x1000, 0x1004, 0x1008 on consecutive cycles.
  - IF/ID = {0x1000, 0xA5A5B5A5, 1} one cycle after each fetch.
- Stall: hold pc_write=if_id_write=0 for 2 cycles while ready arrives for 0x1008.
  - Expect IF/ID frozen, state HELD, imem_req=0.
  - On release: IF/ID = {0x1008, ...}; next request 0x100C.
- Miss bubbles: 3-cycle memory latency.
  - Expect out_valid=0, instruction=NOP_INSTR for 3 cycles, then the valid word; imem_addr stable throughout.
- Redirect during miss: branch_taken, target 0x2000, one cycle after a request to 0x1010.
  - Expect imem_addr stays 0x1010 until ready; data discarded; next request 0x2000; no valid IF/ID from 0x1010.
- Branch beats stall: branch_taken with target 0x3000, pc_write=0, in HELD.
  - Expect IF/ID bubble, hold dropped, next request 0x3000.
- Async reset: assert reset=0 mid-DRAIN, off-edge.
  - Expect all outputs at reset values immediately; first post-release request is 0x1000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEF_*          : default widths and constants used by fetch_top/fetch_fsm
//   fetch_state_e  : fetch controller states
package fetch_pkg;

  localparam int          DEF_ADDR_SIZE  = 32;
  localparam int          DEF_INSTR_SIZE = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // first cycle after reset release, no request
    ST_REQ   = 2'd1,  // requesting pc_q
    ST_DRAIN = 2'd2,  // redirect pending, waiting out the abandoned fetch
    ST_HELD  = 2'd3   // fetched word parked in hold_instr while decode stalls
  } fetch_state_e;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch controller: owns the PC, the fetch state, the pending redirect
// address and the word parked during a decode stall.
// Ports:
//   clk, reset          : clock, async active-low reset
//   stall, if_id_write  : hazard controls from decode
//   branch_taken/target : M-stage redirect
//   imem_*              : instruction memory req/ready handshake
//   ifid_load/bubble    : IF/ID register update commands for fetch_top
//   ifid_pc/ifid_instr  : values to load when ifid_load=1
module fetch_fsm
  import fetch_pkg::*;
#(
  parameter int                    ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int                    INSTR_SIZE = DEF_INSTR_SIZE,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  if_id_write,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_target,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic [INSTR_SIZE-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic                  ifid_load,
  output logic                  ifid_bubble,
  output logic [ADDR_SIZE-1:0]  ifid_pc,
  output logic [INSTR_SIZE-1:0] ifid_instr
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0]  pc_q, pc_d;
  logic [ADDR_SIZE-1:0]  redirect_pc_q, redirect_pc_d;
  logic [INSTR_SIZE-1:0] hold_instr_q, hold_instr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
      hold_instr_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

  // Address is always pc_q; while a request is outstanding pc_q is never
  // changed except on the completing cycle, which keeps the address stable.
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign ifid_pc   = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    hold_instr_d  = hold_instr_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr    = imem_rdata;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (imem_ready) begin
          if (branch_taken) begin
            pc_d        = branch_target;
            ifid_bubble = 1'b1;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            state_d      = ST_HELD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + ADDR_SIZE'(4);
          end
        end else if (branch_taken) begin
          // Cannot retarget a live request; remember where to go once it lands.
          redirect_pc_d = branch_target;
          ifid_bubble   = 1'b1;
          state_d       = ST_DRAIN;
        end else if (if_id_write) begin
          ifid_bubble = 1'b1;
        end
      end

      ST_DRAIN: begin
        ifid_bubble = 1'b1;
        if (branch_taken) redirect_pc_d = branch_target;
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_target : redirect_pc_q;
          state_d = ST_REQ;
        end
      end

      ST_HELD: begin
        ifid_instr = hold_instr_q;
        if (branch_taken) begin
          hold_instr_d = '0;
          pc_d         = branch_target;
          ifid_bubble  = 1'b1;
          state_d      = ST_REQ;
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + ADDR_SIZE'(4);
          state_d   = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/fetch_top.sv
// Instruction fetch stage: drives the instruction memory and the IF/ID
// boundary registers consumed by decode.
// Ports:
//   clk, reset                 : clock, async active-low reset
//   pc_write, if_id_write      : decode hazard controls (0 = hold)
//   branch_taken/branch_target : M-stage redirect
//   imem_req/addr/rdata/ready  : instruction memory handshake
//   out_pc/instruction/out_valid : IF/ID registers (out_valid=0 is a bubble)
module fetch_top
  import fetch_pkg::*;
#(
  parameter int                    ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int                    INSTR_SIZE = DEF_INSTR_SIZE,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = DEF_RESET_PC,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic                  if_id_write,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_target,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic [INSTR_SIZE-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] instruction,
  output logic                  out_valid
);

  logic                  stall;
  logic                  ifid_load;
  logic                  ifid_bubble;
  logic [ADDR_SIZE-1:0]  ifid_pc;
  logic [INSTR_SIZE-1:0] ifid_instr;

  logic [ADDR_SIZE-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_SIZE-1:0] instruction_q, instruction_d;
  logic                  out_valid_q, out_valid_d;

  assign stall = ~pc_write | ~if_id_write;

  fetch_fsm #(
    .ADDR_SIZE  (ADDR_SIZE),
    .INSTR_SIZE (INSTR_SIZE),
    .RESET_PC   (RESET_PC)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .if_id_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_load     (ifid_load),
    .ifid_bubble   (ifid_bubble),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr)
  );

  // Bubble wins over load; a branch flush bubbles regardless of if_id_write.
  always_comb begin
    out_pc_d      = out_pc_q;
    instruction_d = instruction_q;
    out_valid_d   = out_valid_q;
    if (ifid_bubble) begin
      out_pc_d      = '0;
      instruction_d = NOP_INSTR;
      out_valid_d   = 1'b0;
    end else if (ifid_load) begin
      out_pc_d      = ifid_pc;
      instruction_d = ifid_instr;
      out_valid_d   = 1'b1;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pc_q      <= '0;
      instruction_q <= NOP_INSTR;
      out_valid_q   <= 1'b0;
    end else begin
      out_pc_q      <= out_pc_d;
      instruction_q <= instruction_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_pc      = out_pc_q;
  assign instruction = instruction_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: directed scenarios followed by a randomized run, all
// checked cycle by cycle against a reference model of the fetch rules.
module tb_fetch_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b1;
  logic        if_id_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] instruction;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  // memory environment
  int mem_lat = 0;
  int mem_wait = 0;
  bit rand_lat = 0;

  // reference model
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_drain;
  logic [31:0] m_drain_tgt;
  bit          m_held;
  logic [31:0] m_held_word;
  logic [31:0] e_pc, e_instr;
  logic        e_valid;

  fetch_top dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .out_pc        (out_pc),
    .instruction   (instruction),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0000_1000;
    m_drain = 0; m_drain_tgt = '0;
    m_held = 0; m_held_word = '0;
    e_pc = '0; e_instr = '0; e_valid = 0;
    mem_wait = 0;
  endtask

  task automatic bubble();
    e_pc = '0; e_instr = 32'h0; e_valid = 0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cyc(input bit pw, input bit iw, input bit bt, input logic [31:0] tgt);
    bit          stall, rdy, req_s, exp_req;
    logic [31:0] w, nxt;
    pc_write = pw; if_id_write = iw; branch_taken = bt; branch_target = tgt;
    stall = !pw || !iw;
    exp_req = m_started && !m_held;
    #1;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    req_s = imem_req;
    rdy = req_s && (mem_wait >= mem_lat);
    imem_ready = rdy;
    imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    w = mem_word(m_pc);

    if (!m_started) begin
      m_started = 1;
    end else if (m_held) begin
      if (bt) begin
        m_pc = tgt; m_held = 0; bubble();
      end else if (!stall) begin
        e_pc = m_pc; e_instr = m_held_word; e_valid = 1;
        m_pc = m_pc + 32'd4; m_held = 0;
      end
    end else if (m_drain) begin
      bubble();
      nxt = bt ? tgt : m_drain_tgt;
      if (rdy) begin
        m_pc = nxt; m_drain = 0;
      end else m_drain_tgt = nxt;
    end else if (rdy) begin
      if (bt) begin
        m_pc = tgt; bubble();
      end else if (stall) begin
        m_held = 1; m_held_word = w;
      end else begin
        e_pc = m_pc; e_instr = w; e_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end else if (bt) begin
      m_drain = 1; m_drain_tgt = tgt; bubble();
    end else if (iw) begin
      bubble();
    end

    @(posedge clk); #1;
    chk("out_pc", out_pc, e_pc);
    chk("instruction", instruction, e_instr);
    chk("out_valid", out_valid, e_valid);
    if (rdy) begin
      mem_wait = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
    end else if (req_s) mem_wait++;
    imem_ready = 0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk);
    reset = 1;

    // zero-wait streaming
    mem_lat = 0;
    cyc(1, 1, 0, 0);                                  // IDLE
    cyc(1, 1, 0, 0);                                  // fetch 0x1000
    chk("first_pc", out_pc, 32'h0000_1000);
    chk("first_instr", instruction, 32'hA5A5_B5A5);
    chk("first_valid", out_valid, 1);
    cyc(1, 1, 0, 0);                                  // fetch 0x1004
    chk("second_pc", out_pc, 32'h0000_1004);

    // stall while 0x1008 completes
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_req", imem_req, 0);
    chk("held_pc_frozen", out_pc, 32'h0000_1004);
    cyc(1, 1, 0, 0);
    chk("release_pc", out_pc, 32'h0000_1008);
    chk("release_instr", instruction, 32'h0000_1008 ^ 32'hA5A5_A5A5);

    // 3-cycle miss on 0x100C
    mem_lat = 3;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0);
      chk("miss_bubble", out_valid, 0);
      chk("miss_addr", imem_addr, 32'h0000_100C);
    end
    cyc(1, 1, 0, 0);
    chk("miss_done_pc", out_pc, 32'h0000_100C);

    // redirect during miss on 0x1010
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h0000_2000);
    cyc(1, 1, 0, 0);
    chk("drain_addr", imem_addr, 32'h0000_1010);
    cyc(1, 1, 0, 0);
    chk("drain_no_valid", out_valid, 0);
    mem_lat = 0;
    cyc(1, 1, 0, 0);
    chk("redirect_pc", out_pc, 32'h0000_2000);

    // branch beats stall in HELD
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h0000_3000);
    chk("bt_stall_bubble", out_valid, 0);
    chk("bt_stall_addr", imem_addr, 32'h0000_3000);
    cyc(1, 1, 0, 0);

    // PC wrap
    cyc(1, 1, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    cyc(1, 1, 0, 0);

    // randomized run
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      bit pw, iw, bt;
      logic [31:0] tgt;
      pw = ($urandom_range(0, 9) != 0);
      iw = ($urandom_range(0, 9) != 0);
      bt = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: tgt = $urandom;
        1: tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom & 32'h0000_FFFC;
      endcase
      cyc(pw, iw, bt, tgt);
    end
    rand_lat = 0;

    // async reset in the middle of a drain
    mem_lat = 5;
    while (m_held || m_drain) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h0000_4000);
    cyc(1, 1, 0, 0);
    #2 reset = 0;
    #1;
    chk("areset_req", imem_req, 0);
    chk("areset_addr", imem_addr, 32'h0000_1000);
    chk("areset_out_pc", out_pc, 0);
    chk("areset_instr", instruction, 0);
    chk("areset_valid", out_valid, 0);
    model_reset();
    mem_lat = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("post_reset_pc", out_pc, 32'h0000_1000);
    cyc(1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
